// File: rtl/ntt_bfly_post.sv
// Post-reduction Cooley-Tukey butterfly: E=(A+C) mod q, O=(A-C) mod q.
// Delays A/mode/valid to meet the reducer output and flags the last pair.
module ntt_bfly_post #(
  parameter int DATA_SIZE = 32,
  parameter int MR_LAT    = 4,
  parameter int N_PAIRS   = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] q,
  input  logic                 clear,
  input  logic                 mode,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] A,
  input  logic [DATA_SIZE-1:0] C,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] E,
  output logic [DATA_SIZE-1:0] O,
  output logic                 out_last
);

  localparam int DW = DATA_SIZE;
  localparam int CW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_PAIRS - 1);

  logic [MR_LAT-1:0] dl_v_q;
  logic [MR_LAT-1:0] dl_m_q;
  logic [DW-1:0]     dl_a_q [MR_LAT];

  logic          s1_v_q, s1_m_q;
  logic [DW:0]   s1_sum_q, s1_diff_q;
  logic [DW:0]   s1_sum_d, s1_diff_d;

  logic          out_valid_q;
  logic [DW-1:0] e_q, o_q, e_d, o_d;
  logic [DW:0]   sum_red;
  logic [CW-1:0] cnt_q;

  logic [DW-1:0] a_tap;
  logic          v_tap, m_tap;

  assign a_tap = dl_a_q[MR_LAT-1];
  assign v_tap = dl_v_q[MR_LAT-1];
  assign m_tap = dl_m_q[MR_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_v_q <= '0;
      dl_m_q <= '0;
      for (int i = 0; i < MR_LAT; i++) dl_a_q[i] <= '0;
    end else begin
      dl_v_q[0] <= in_valid & ~clear;
      dl_m_q[0] <= mode;
      dl_a_q[0] <= A;
      for (int i = 1; i < MR_LAT; i++) begin
        dl_v_q[i] <= dl_v_q[i-1] & ~clear;
        dl_m_q[i] <= dl_m_q[i-1];
        dl_a_q[i] <= dl_a_q[i-1];
      end
    end
  end

  // Passthrough reuses the sum/diff registers to carry A and C.
  always_comb begin
    s1_sum_d  = {1'b0, a_tap} + {1'b0, C};
    s1_diff_d = {1'b0, a_tap} - {1'b0, C};
    if (m_tap) begin
      s1_sum_d  = {1'b0, a_tap};
      s1_diff_d = {1'b0, C};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q    <= 1'b0;
      s1_m_q    <= 1'b0;
      s1_sum_q  <= '0;
      s1_diff_q <= '0;
    end else begin
      s1_v_q <= v_tap & ~clear;
      if (v_tap) begin
        s1_m_q    <= m_tap;
        s1_sum_q  <= s1_sum_d;
        s1_diff_q <= s1_diff_d;
      end
    end
  end

  always_comb begin
    sum_red = s1_sum_q - {1'b0, q};
    e_d     = s1_sum_q[DW-1:0];
    o_d     = s1_diff_q[DW-1:0];
    if (!s1_m_q) begin
      if (s1_sum_q >= {1'b0, q}) e_d = sum_red[DW-1:0];
      if (s1_diff_q[DW])         o_d = s1_diff_q[DW-1:0] + q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      e_q         <= '0;
      o_q         <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= s1_v_q & ~clear;
      if (s1_v_q) begin
        e_q <= e_d;
        o_q <= o_d;
      end
      if (clear)
        cnt_q <= '0;
      else if (out_valid_q)
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign E         = e_q;
  assign O         = o_q;
  assign out_last  = out_valid_q & (cnt_q == LAST);

endmodule

// File: tb/tb_ntt_bfly_post.sv
// Directed bench for ntt_bfly_post: vectors are scheduled per cycle
// and every output is compared on the falling edge.
module tb_ntt_bfly_post;

  localparam int DW = 32;
  localparam int LAT = 4;
  localparam int NP = 128;
  localparam int NC = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] q = 32'd7681;
  logic          clear = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] A = '0;
  logic [DW-1:0] C = '0;
  logic          out_valid;
  logic [DW-1:0] E, O;
  logic          out_last;

  ntt_bfly_post #(.DATA_SIZE(DW), .MR_LAT(LAT), .N_PAIRS(NP)) dut (
    .clk(clk), .reset(reset), .q(q), .clear(clear), .mode(mode),
    .in_valid(in_valid), .A(A), .C(C), .out_valid(out_valid),
    .E(E), .O(O), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [DW-1:0] c_sched [NC];
  bit            exp_v   [NC];
  logic [DW-1:0] exp_e   [NC];
  logic [DW-1:0] exp_o   [NC];
  bit            exp_clr [NC];
  bit            exp_rst [NC];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  int ecnt = 0;
  logic [DW-1:0] he = '0, ho = '0;

  always @(negedge clk) begin
    if (exp_rst[cyc]) begin
      ecnt = 0;
      he = '0;
      ho = '0;
    end
    chk("out_valid", 32'(out_valid), 32'(exp_v[cyc]));
    if (exp_v[cyc]) begin
      chk("E", E, exp_e[cyc]);
      chk("O", O, exp_o[cyc]);
      chk("out_last", 32'(out_last), 32'(ecnt == NP - 1));
      he = exp_e[cyc];
      ho = exp_o[cyc];
      ecnt = (ecnt == NP - 1) ? 0 : ecnt + 1;
    end else begin
      chk("E_hold", E, he);
      chk("O_hold", O, ho);
      chk("last_idle", 32'(out_last), 32'd0);
    end
    if (exp_clr[cyc]) ecnt = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
    C = c_sched[cyc];
    in_valid = 1'b0;
    mode = 1'b0;
    clear = 1'b0;
  endtask

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] c,
                       input logic m, input logic [DW-1:0] e,
                       input logic [DW-1:0] o, input bit rec);
    A = a;
    mode = m;
    in_valid = 1'b1;
    c_sched[cyc + LAT] = c;
    if (rec) begin
      exp_v[cyc + LAT + 2] = 1'b1;
      exp_e[cyc + LAT + 2] = e;
      exp_o[cyc + LAT + 2] = o;
    end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      c_sched[i] = '0;
      exp_v[i] = 1'b0;
      exp_e[i] = '0;
      exp_o[i] = '0;
      exp_clr[i] = 1'b0;
      exp_rst[i] = 1'b0;
    end
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_E", E, 32'd0);
    chk("rst_O", O, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    step();
    step();
    reset = 1'b1;
    while (cyc < 10) step();

    issue(100, 50, 1'b0, 150, 50, 1);
    repeat (10) step();

    issue(7000, 1000, 1'b0, 319, 6000, 1);  step();
    issue(10, 20, 1'b0, 30, 7671, 1);       step();
    issue(0, 7680, 1'b0, 7680, 1, 1);       step();
    issue(3840, 3841, 1'b0, 0, 7680, 1);    step();
    issue(1234, 5678, 1'b1, 1234, 5678, 1); step();
    issue(5, 3, 1'b0, 8, 2, 1);             step();
    issue(5, 3, 1'b1, 5, 3, 1);             step();
    issue(7680, 7680, 1'b0, 7679, 0, 1);    step();
    issue(7680, 0, 1'b1, 7680, 0, 1);       step();
    repeat (10) step();

    issue(11, 22, 1'b0, 0, 0, 0); step();
    issue(33, 44, 1'b0, 0, 0, 0); step();
    issue(55, 66, 1'b1, 0, 0, 0); step();
    issue(77, 88, 1'b0, 0, 0, 0);
    clear = 1'b1;
    exp_clr[cyc] = 1'b1;
    step();
    repeat (10) step();

    for (int i = 0; i < 2 * NP; i++) begin
      issue(DW'(i * 20), DW'(i * 10), 1'b0, DW'(i * 30), DW'(i * 10), 1);
      step();
    end
    repeat (10) step();

    issue(1, 2, 1'b0, 3, 7680, 1); step();
    issue(3, 4, 1'b0, 7, 7680, 1); step();
    issue(5, 6, 1'b0, 11, 7680, 1); step();
    issue(7, 8, 1'b0, 15, 7680, 1); step();
    repeat (3) step();
    #2;
    reset = 1'b0;
    exp_rst[cyc] = 1'b1;
    for (int i = cyc; i < NC; i++) exp_v[i] = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_E", E, 32'd0);
    chk("arst_O", O, 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();
    issue(4000, 4000, 1'b0, 319, 0, 1); step();
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
